// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// default widths, memory window, timeout limit and FSM/op encodings.
package mem_access_ctrl_pkg;

    localparam int unsigned AddressLen     = 32;
    localparam int unsigned InstructionLen = 32;
    localparam int unsigned MemBaseDef     = 1024;
    localparam int unsigned MemBytesDef    = 256;
    localparam int unsigned TimeoutDef     = 255;
    localparam int unsigned CntW           = 8;

    typedef enum logic [1:0] {
        MacIdle   = 2'd0,
        MacAccess = 2'd1,
        MacDone   = 2'd2
    } mac_state_e;

    typedef enum logic {
        OpRead  = 1'b0,
        OpWrite = 1'b1
    } mac_op_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory (slave).
interface mem_access_ctrl_if #(
    parameter int unsigned AddrW = 32,
    parameter int unsigned DataW = 32
);
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
    logic             read;
    logic             write;
    logic             ready;
    logic [DataW-1:0] rdata;

    modport master (output addr, output wdata, output read, output write,
                    input  ready, input  rdata);
    modport slave  (input  addr, input  wdata, input  read, input  write,
                    output ready, output rdata);
endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// ACCESS-cycle counter; tc flags the cycle that is the Limit-th one since clear.
module mem_access_ctrl_timeout_cnt #(
    parameter int unsigned Width = 8,
    parameter int unsigned Limit = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed ACCESS cycles, so Limit-1 marks the last allowed one.
    assign tc = (cnt_q == Width'(Limit - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator: turns pipeline load/store requests into data-memory strobes,
// waits for ready (with timeout), captures read data and freezes the pipeline meanwhile.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = AddressLen,
    parameter int unsigned DATA_W    = InstructionLen,
    parameter int unsigned MEM_BASE  = MemBaseDef,
    parameter int unsigned MEM_BYTES = MemBytesDef,
    parameter int unsigned TIMEOUT   = TimeoutDef
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    mem_access_ctrl_if.master mem,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              freeze,
    output logic              align_err,
    output logic              range_err,
    output logic              timeout_err
);
    localparam logic [ADDR_W-1:0] LoAddr = ADDR_W'(MEM_BASE);
    localparam logic [ADDR_W-1:0] HiAddr = ADDR_W'(MEM_BASE + MEM_BYTES - 4);

    mac_state_e        state_q, state_d;
    mac_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              align_q, align_d;
    logic              range_q, range_d;
    logic              tmo_q, tmo_d;

    logic              req;
    logic [ADDR_W-1:0] addr_aligned;
    logic              in_range;
    logic              cnt_clr, cnt_inc, cnt_tc;

    assign req          = mem_r_en | mem_w_en;
    assign addr_aligned = {addr_in[ADDR_W-1:2], 2'b00};
    assign in_range     = (addr_aligned >= LoAddr) && (addr_aligned <= HiAddr);

    mem_access_ctrl_timeout_cnt #(
        .Width (CntW),
        .Limit (TIMEOUT)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        align_d = align_q;
        range_d = range_q;
        tmo_d   = tmo_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            MacIdle: begin
                cnt_clr = 1'b1;
                if (req) begin
                    addr_d  = addr_aligned;
                    wdata_d = wdata_in;
                    op_d    = mem_w_en ? OpWrite : OpRead;
                    if (addr_in[1:0] != 2'b00) begin
                        align_d = 1'b1;
                    end
                    // Out-of-window accesses never reach the memory.
                    if (!in_range) begin
                        range_d = 1'b1;
                        if (!mem_w_en) begin
                            rdata_d = '0;
                        end
                        state_d = MacDone;
                    end else begin
                        state_d = MacAccess;
                    end
                end
            end
            MacAccess: begin
                cnt_inc = 1'b1;
                if (mem.ready) begin
                    if (op_q == OpRead) begin
                        rdata_d = mem.rdata;
                    end
                    state_d = MacDone;
                end else if (cnt_tc) begin
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                    state_d = MacDone;
                end
            end
            MacDone: begin
                cnt_clr = 1'b1;
                state_d = MacIdle;
            end
            default: state_d = MacIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MacIdle;
            op_q    <= OpRead;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            align_q <= 1'b0;
            range_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            align_q <= align_d;
            range_q <= range_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
    assign mem.read    = (state_q == MacAccess) && (op_q == OpRead);
    assign mem.write   = (state_q == MacAccess) && (op_q == OpWrite);
    assign rdata_out   = rdata_q;
    assign rdata_valid = (state_q == MacDone) && (op_q == OpRead);
    // Low in DONE so the pipeline advances exactly once per access.
    assign freeze      = !rst && (((state_q == MacIdle) && req) || (state_q == MacAccess));
    assign align_err   = align_q;
    assign range_err   = range_q;
    assign timeout_err = tmo_q;
endmodule
